core_data_mem_responder: RTL



---
 rtl/core_data_mem_responder_if.sv | 26 ++
 rtl/core_data_mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/core_data_mem_responder_if.sv
// Core data-memory bus: request from the core, completion back.
// Ready/Err are one-cycle pulses; MemData is qualified by Ready.
interface core_data_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] RWAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] MemData;
  logic                  Ready;
  logic                  Err;

  modport master (
    output MemRead, MemWrite,
    output RWAddress, WriteData,
    input  MemData, Ready, Err
  );

  modport slave (
    input  MemRead, MemWrite,
    input  RWAddress, WriteData,
    output MemData, Ready, Err
  );
endinterface

// File: rtl/core_data_mem_responder.sv
// Data-memory target: word RAM plus GPIO out/in registers,
// programmable wait states, Ready/Err completion pulse.
module core_data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1001_0000,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE   = 32'h1001_0400,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  core_data_mem_responder_if.slave bus,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] RAM_SPAN =
    ADDR_WIDTH'(4 * DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] IN_ADDR =
    IO_BASE + ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [3:0]            r_cnt;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_memdata;
  logic [DATA_WIDTH-1:0] r_gpio_out;
  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_ram;
  logic                  w_is_out;
  logic                  w_is_in;
  logic                  w_err;
  logic                  w_resp;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_req    = bus.MemRead | bus.MemWrite;
  assign w_off    = r_addr - BASE_ADDR;
  assign w_idx    = w_off[IDX_W+1:2];
  assign w_in_ram = (r_addr >= BASE_ADDR) &&
                    (w_off < RAM_SPAN);
  assign w_is_out = (r_addr == IO_BASE);
  assign w_is_in  = (r_addr == IN_ADDR);

  // Rejected accesses leave every register and RAM word untouched.
  assign w_err = (r_addr[1:0] != 2'b00) ||
                 !(w_in_ram || w_is_out || w_is_in) ||
                 (r_wr && w_is_in) ||
                 (r_rd && r_wr);

  assign w_resp  = (r_state == RESP);
  assign w_rd_ok = w_resp && r_rd && !w_err;
  assign w_wr_ok = w_resp && r_wr && !w_err;

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_in_ram: w_rdata = r_mem[w_idx];
      w_is_out: w_rdata = r_gpio_out;
      w_is_in:  w_rdata = r_sync2;
      default:  w_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nx = RESP;
        end
      end
      RESP:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_memdata  <= '0;
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (r_state == IDLE && w_req) begin
        r_rd    <= bus.MemRead;
        r_wr    <= bus.MemWrite;
        r_addr  <= bus.RWAddress;
        r_wdata <= bus.WriteData;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_wr_ok && w_is_out) begin
        r_gpio_out <= r_wdata;
      end
      if (w_rd_ok) begin
        r_memdata <= w_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok && w_in_ram) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // Read data is live during the response cycle, then held.
  assign bus.MemData = w_rd_ok ? w_rdata : r_memdata;
  assign bus.Ready   = w_resp;
  assign bus.Err     = w_resp && w_err;
  assign gpio_out    = r_gpio_out;

endmodule
